// File: rtl/array_prod_mac.sv
// Signed Q(QN).(QM) dot product of two packed vectors, one MAC per clock, saturated scalar out.
// Latency ARRAY_SZ+1 cycles after reset release; no backpressure, result held until reset.
module array_prod_mac #(
    parameter int ARRAY_SZ = 8,
    parameter int QN       = 6,
    parameter int QM       = 11,
    parameter int BITWIDTH = QN + QM + 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [ARRAY_SZ*BITWIDTH-1:0] arrayA,
    input  logic [ARRAY_SZ*BITWIDTH-1:0] arrayB,
    output logic                         dataReady,
    output logic [BITWIDTH-1:0]          result
);

    localparam int IDXW = $clog2(ARRAY_SZ) + 1;
    localparam int PRODW = 2 * BITWIDTH;
    localparam int ACCW = PRODW + $clog2(ARRAY_SZ);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ARRAY_SZ);
    localparam logic signed [ACCW-1:0] MAX_VAL = ACCW'((2 ** (BITWIDTH - 1)) - 1);
    localparam logic signed [ACCW-1:0] MIN_VAL = -MAX_VAL - ACCW'(1);

    logic signed [BITWIDTH-1:0] elemA [ARRAY_SZ];
    logic signed [BITWIDTH-1:0] elemB [ARRAY_SZ];
    logic signed [PRODW-1:0]    prod;
    logic signed [ACCW-1:0]     acc;
    logic signed [ACCW-1:0]     shifted;
    logic [BITWIDTH-1:0]        satVal;
    logic [IDXW-1:0]            idx;
    logic                       done;

    genvar g;
    generate
        for (g = 0; g < ARRAY_SZ; g++) begin : gUnpack
            assign elemA[g] = arrayA[g*BITWIDTH +: BITWIDTH];
            assign elemB[g] = arrayB[g*BITWIDTH +: BITWIDTH];
        end
    endgenerate

    // Element mux driven by idx; idx == ARRAY_SZ selects nothing.
    always_comb begin
        prod = '0;
        for (int i = 0; i < ARRAY_SZ; i++) begin
            if (idx == IDXW'(i)) begin
                prod = elemA[i] * elemB[i];
            end
        end
    end

    // Arithmetic shift truncates toward minus infinity before clamping.
    always_comb begin
        shifted = acc >>> QM;
        satVal  = shifted[BITWIDTH-1:0];
        if (shifted > MAX_VAL) begin
            satVal = MAX_VAL[BITWIDTH-1:0];
        end else if (shifted < MIN_VAL) begin
            satVal = MIN_VAL[BITWIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            acc    <= '0;
            idx    <= '0;
            done   <= 1'b0;
            result <= '0;
        end else if (idx < LAST_IDX) begin
            acc <= acc + ACCW'(prod);
            idx <= idx + IDXW'(1);
        end else if (!done) begin
            result <= satVal;
            done   <= 1'b1;
        end
    end

    assign dataReady = done;

endmodule

// File: tb/tb_array_prod_mac.sv
// Scoreboard bench for array_prod_mac: default instance plus an ARRAY_SZ=1 instance.
module tb_array_prod_mac;

    localparam int N  = 8;
    localparam int W  = 18;
    localparam int QM = 11;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [N*W-1:0]  arrayA = '0;
    logic [N*W-1:0]  arrayB = '0;
    logic            dataReady;
    logic [W-1:0]    result;

    logic            reset1 = 1'b0;
    logic [W-1:0]    arrayA1 = '0;
    logic [W-1:0]    arrayB1 = '0;
    logic            dataReady1;
    logic [W-1:0]    result1;

    int nChecks = 0;
    int nFail   = 0;
    logic [W-1:0] expQ [$];

    always #5 clock = ~clock;

    array_prod_mac #(.ARRAY_SZ(N), .QN(6), .QM(QM)) dut (
        .clock(clock), .reset(reset), .arrayA(arrayA), .arrayB(arrayB),
        .dataReady(dataReady), .result(result)
    );

    array_prod_mac #(.ARRAY_SZ(1), .QN(6), .QM(QM)) dut1 (
        .clock(clock), .reset(reset1), .arrayA(arrayA1), .arrayB(arrayB1),
        .dataReady(dataReady1), .result(result1)
    );

    function automatic logic [W-1:0] model(input logic signed [W-1:0] a [N],
                                           input logic signed [W-1:0] b [N]);
        longint sum = 0;
        longint sh;
        logic [63:0] tmp;
        for (int i = 0; i < N; i++) sum += longint'(a[i]) * longint'(b[i]);
        sh = sum >>> QM;
        if (sh > 131071) sh = 131071;
        if (sh < -131072) sh = -131072;
        tmp = sh;
        return tmp[W-1:0];
    endfunction

    // Holds reset for two edges, loads vectors, pushes the expectation, releases reset.
    task automatic apply_vectors(input logic signed [W-1:0] a [N],
                                 input logic signed [W-1:0] b [N]);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            arrayA[i*W +: W] = a[i];
            arrayB[i*W +: W] = b[i];
        end
        expQ.push_back(model(a, b));
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic fill(input int va, input int vb,
                        output logic signed [W-1:0] a [N], output logic signed [W-1:0] b [N]);
        for (int i = 0; i < N; i++) begin
            a[i] = W'(va);
            b[i] = W'(vb);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        nChecks++;
        if (dataReady !== 1'b0 || result !== '0) begin
            nFail++;
            $display("FAIL reset_state: dataReady=%b result=%h required 0/00000", dataReady, result);
        end
    endtask

    task automatic test_arith;
        logic signed [W-1:0] a [N];
        logic signed [W-1:0] b [N];
        logic [W-1:0] exp;
        int va [6] = '{400, -2048, 1, -1, 32'h1FFFF, 32'h1FFFF};
        int vb [6] = '{2048, 2048, 1, 1, 32'h1FFFF, -131072};
        logic [W-1:0] fixed [6] = '{18'h00C80, 18'h3C000, 18'h00000, 18'h3FFFF, 18'h1FFFF, 18'h20000};
        for (int p = 0; p < 7; p++) begin
            if (p < 6) fill(va[p], vb[p], a, b);
            else begin
                for (int i = 0; i < N; i++) begin
                    a[i] = W'($urandom_range(0, 262143));
                    b[i] = W'($urandom_range(0, 262143));
                end
            end
            apply_vectors(a, b);
            for (int k = 1; k <= N + 1; k++) begin
                @(posedge clock);
                #1;
                nChecks++;
                if (dataReady !== (k == N + 1)) begin
                    nFail++;
                    $display("FAIL arith%0d_ready_edge%0d: dataReady=%b required %b", p, k, dataReady, k == N + 1);
                end
            end
            exp = expQ.pop_front();
            nChecks++;
            if (result !== exp) begin
                nFail++;
                $display("FAIL arith%0d_result: result=%h required %h", p, result, exp);
            end
            if (p < 6) begin
                nChecks++;
                if (result !== fixed[p]) begin
                    nFail++;
                    $display("FAIL arith%0d_fixed: result=%h required %h", p, result, fixed[p]);
                end
            end
        end
    endtask

    task automatic test_mid_reset;
        logic signed [W-1:0] a [N];
        logic signed [W-1:0] b [N];
        logic [W-1:0] exp;
        fill(-5000, 7000, a, b);
        apply_vectors(a, b);
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b0;
        void'(expQ.pop_front());
        @(posedge clock);
        #1;
        nChecks++;
        if (dataReady !== 1'b0 || result !== '0) begin
            nFail++;
            $display("FAIL mid_reset_clear: dataReady=%b result=%h required 0/00000", dataReady, result);
        end
        fill(400, 2048, a, b);
        apply_vectors(a, b);
        repeat (N) @(posedge clock);
        #1;
        nChecks++;
        if (dataReady !== 1'b0) begin
            nFail++;
            $display("FAIL mid_reset_early: dataReady=%b required 0 at edge %0d", dataReady, N);
        end
        @(posedge clock);
        #1;
        exp = expQ.pop_front();
        nChecks++;
        if (dataReady !== 1'b1 || result !== exp) begin
            nFail++;
            $display("FAIL mid_reset_rerun: dataReady=%b result=%h required 1/%h", dataReady, result, exp);
        end
    endtask

    task automatic test_hold;
        logic [W-1:0] held;
        int bad = 0;
        held = result;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            for (int i = 0; i < N; i++) begin
                arrayA[i*W +: W] = W'($urandom);
                arrayB[i*W +: W] = W'($urandom);
            end
            @(posedge clock);
            #1;
            if (dataReady !== 1'b1 || result !== held) bad++;
        end
        nChecks++;
        if (bad != 0 || held !== 18'h00C80) begin
            nFail++;
            $display("FAIL hold: %0d cycles changed, result=%h required %h held", bad, result, 18'h00C80);
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        nChecks++;
        if (dataReady !== 1'b0 || result !== '0) begin
            nFail++;
            $display("FAIL reset_while_done: dataReady=%b result=%h required 0/00000", dataReady, result);
        end
    endtask

    task automatic test_pulse_reset;
        logic signed [W-1:0] a [N];
        logic signed [W-1:0] b [N];
        logic [W-1:0] exp;
        for (int i = 0; i < N; i++) begin
            a[i] = W'(i * 1000 - 3000);
            b[i] = W'(2048 - i * 700);
        end
        exp = model(a, b);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            arrayA[i*W +: W] = a[i];
            arrayB[i*W +: W] = b[i];
        end
        repeat (N + 3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        expQ.push_back(exp);
        @(negedge clock);
        reset = 1'b1;
        repeat (N) @(posedge clock);
        #1;
        nChecks++;
        if (dataReady !== 1'b0) begin
            nFail++;
            $display("FAIL pulse_reset_early: dataReady=%b required 0", dataReady);
        end
        @(posedge clock);
        #1;
        exp = expQ.pop_front();
        nChecks++;
        if (dataReady !== 1'b1 || result !== exp) begin
            nFail++;
            $display("FAIL pulse_reset_result: dataReady=%b result=%h required 1/%h", dataReady, result, exp);
        end
    endtask

    task automatic test_size1;
        logic [W-1:0] exp;
        exp = W'(-4608);
        @(negedge clock);
        reset1 = 1'b0;
        arrayA1 = W'(-6144);
        arrayB1 = W'(1536);
        @(negedge clock);
        reset1 = 1'b1;
        @(posedge clock);
        #1;
        nChecks++;
        if (dataReady1 !== 1'b0) begin
            nFail++;
            $display("FAIL size1_edge1: dataReady=%b required 0", dataReady1);
        end
        @(posedge clock);
        #1;
        nChecks++;
        if (dataReady1 !== 1'b1 || result1 !== exp) begin
            nFail++;
            $display("FAIL size1_edge2: dataReady=%b result=%h required 1/%h", dataReady1, result1, exp);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_mid_reset();
        test_hold();
        test_pulse_reset();
        test_size1();
        nChecks++;
        if (expQ.size() != 0) begin
            nFail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/array_prod_mac.md
# array_prod_mac

Signed fixed-point dot-product engine: multiplies two packed vectors of `ARRAY_SZ` Q`QN`.`QM` elements element-wise and accumulates the products into one Q`QN`.`QM` scalar. It sits after the LSTM hidden layer as the output perceptron. The weight vector goes on `arrayA`, the hidden-state vector on `arrayB`, and the scalar feeds the sigmoid/cost stage. Computation is sequential, one multiply-accumulate (MAC) per clock, and restarts every time reset is released.

## Interface
Parameters:
- `ARRAY_SZ`, 8: number of elements per vector (≥1).
- `QN`, 6: integer bits (excluding sign).
- `QM`, 11: fractional bits.
- `BITWIDTH` (derived): `QN+QM+1` = 18, the element/result width.

Ports:
- `clock` input, 1: single clock; all logic on its rising edge.
- `reset` input, 1: synchronous, active-low. While low, the block is held in its initial state; releasing it starts a new computation.
- `arrayA` input, `ARRAY_SZ*BITWIDTH`: vector A. Element i is at `[i*BITWIDTH +: BITWIDTH]`, two's complement.
- `arrayB` input, `ARRAY_SZ*BITWIDTH`: vector B, same packing.
- `dataReady` output, 1: high when `result` is valid.
- `result` output, `BITWIDTH`: Σ A[i]·B[i] in Q`QN`.`QM`, saturated.

## Operation
- **State:**
  - element index `idx` (width `clog2(ARRAY_SZ)+1`),
  - signed accumulator `acc` of `2*BITWIDTH + clog2(ARRAY_SZ)` bits (full precision, never overflows),
  - a done flag.
- **Reset (reset=0 at a rising edge):**
  - `acc`=0, `idx`=0, done=0.
  - `dataReady`=0, `result`=0.
- **MAC phase (reset=1, idx<ARRAY_SZ):**
  - `acc += $signed(A[idx]) * $signed(B[idx])` (36-bit product, sign-extended).
  - `idx` increments.
- **Finish (reset=1, idx==ARRAY_SZ, not done):**
  - `result <= sat(acc >>> QM)`, an arithmetic shift, i.e. truncation toward −∞.
  - `dataReady <= 1`, done=1.
- **Saturation:**
  - shifted value > 2^(BITWIDTH−1)−1 gives 0x1FFFF (for 18 bits);
  - shifted value < −2^(BITWIDTH−1) gives 0x20000.
- **Done state:** `result` and `dataReady` are held; the inputs are ignored until reset goes low.
- **Input stability:** the inputs are sampled element by element during the MAC phase. The driver must hold `arrayA` and `arrayB` stable from reset release until `dataReady` rises. Changes after that have no effect.
- **Arithmetic:** all operands are signed. No rounding other than the truncating shift. No intermediate saturation.

## Timing
- Let edge 1 be the first rising edge at which reset=1.
- Edges 1..`ARRAY_SZ` process elements 0..`ARRAY_SZ`−1.
- At edge `ARRAY_SZ`+1, `result` and `dataReady` register. Latency is `ARRAY_SZ`+1 cycles (9 for defaults).
- `dataReady` is a level, not a pulse. It stays high until reset is asserted, so a consumer may use its rising edge.
- **Reset mid-computation:** the next edge clears everything, with no partial result.
  - After re-release, a full `ARRAY_SZ`+1 cycle computation runs.
- **Reset while done:** `dataReady` and `result` drop to 0 on the first edge with reset=0.
- **Reset pulsed for one cycle:** behaves the same as a longer reset.
- **`ARRAY_SZ`=1:** latency is 2 cycles.

## Test plan
- A[i]=400, B[i]=2048 (1.0) for all 8 elements; release reset → `dataReady` rises exactly 9 edges later; `result`=3200 (0x00C80).
- A[i]=−2048, B[i]=2048 → `result`=−16384 (0x3C000); check `dataReady` is 0 at edges 1–8.
- **Truncation toward −∞:**
  - A[i]=1, B[i]=1 → `result`=0;
  - A[i]=−1, B[i]=1 → `result`=0x3FFFF (−1).
- **Saturation:**
  - A[i]=B[i]=0x1FFFF → `result`=0x1FFFF;
  - A[i]=0x1FFFF, B[i]=0x20000 → `result`=0x20000.
- **Reset mid-operation:**
  - Pull reset low at edge 4 → the next edge gives `dataReady`=0, `result`=0.
  - Re-release with vectors A[i]=400, B[i]=2048 → 3200 after exactly 9 edges; no residue from the aborted run.
- **Hold behaviour:**
  - After done, change `arrayA` and `arrayB` arbitrarily for 20 cycles → `result` and `dataReady` remain unchanged.
  - Then assert reset → both go to 0.
